// File: rtl/scan_code_gen.sv
// scan_code_gen
//   Steps a 2-bit code through digit positions 0..LAST_IDX. Each position is
//   held for PRESCALE clock cycles. The code feeds decoder2_4_top, which turns
//   it into a rotating one-hot select. The data nibble for the current
//   position is taken from a shadow copy of `data`. The shadow is refreshed
//   only when the code wraps back to 0, so a frame is always internally
//   consistent.
//
//   Parameters
//     PRESCALE   cycles each code is held (1..65535)
//     LAST_IDX   highest code before wrapping to 0 (0..3)
//
//   Optional feature
//     SCAN_BLANK_EN  when defined, every dwell end is followed by a single
//                    BLANK cycle. In that cycle valid=0 and a/nibble hold.
//                    The code then advances when BLANK is left.
//
//   Ports
//     clk         in   system clock, rising edge
//     reset_n     in   asynchronous active-low reset
//     en          in   scan enable (level); sampled 0 forces IDLE
//     data[15:0]  in   four nibbles; nibble k = data[4k+3:4k]
//     a[1:0]      out  current code (to decoder2_4_top.a)
//     nibble[3:0] out  shadow nibble selected by a
//     valid       out  a/nibble meaningful this cycle
//     frame_done  out  one-cycle pulse with the first cycle of code 0 after a wrap
//
//   State   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | not scanning; a=0, valid=0; waits for en
//   SHOW    | presenting a/nibble; dwell counter running
//   BLANK   | (SCAN_BLANK_EN only) one dead cycle between digits
module scan_code_gen #(
  parameter int PRESCALE = 4,
  parameter int LAST_IDX = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] data,
  output logic [1:0]  a,
  output logic [3:0]  nibble,
  output logic        valid,
  output logic        frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [1:0]    CODE_LAST = 2'(LAST_IDX);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
`ifdef SCAN_BLANK_EN
  localparam logic [1:0] ST_BLANK = 2'd2;
`endif

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [1:0]    a_d;
  logic [3:0]    nibble_d;
  logic          valid_d;
  logic          frame_done_d;

  logic          dwell_end;
  logic          at_last;
  logic [1:0]    a_next;
  logic          advance;

  function automatic logic [3:0] pick_nibble(input logic [15:0] word,
                                             input logic [1:0]  idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = word[3:0];
      2'd1:    r = word[7:4];
      2'd2:    r = word[11:8];
      default: r = word[15:12];
    endcase
    return r;
  endfunction

  assign dwell_end = (cnt_q == CNT_LAST);
  assign at_last   = (a == CODE_LAST);
  assign a_next    = at_last ? 2'd0 : a + 2'd1;

  // The code advances at the end of SHOW. With blanking enabled it advances
  // when BLANK is left instead.
`ifdef SCAN_BLANK_EN
  assign advance = en && (state_q == ST_BLANK);
`else
  assign advance = en && (state_q == ST_SHOW) && dwell_end;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    a_d          = a;
    nibble_d     = nibble;
    valid_d      = valid;
    frame_done_d = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      a_d     = 2'd0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          shadow_d = data;
          a_d      = 2'd0;
          cnt_d    = '0;
          nibble_d = data[3:0];
          valid_d  = 1'b1;
          state_d  = ST_SHOW;
        end
        ST_SHOW: begin
          if (dwell_end) begin
            cnt_d = '0;
`ifdef SCAN_BLANK_EN
            state_d = ST_BLANK;
            valid_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef SCAN_BLANK_EN
        ST_BLANK: begin
          state_d = ST_SHOW;
          valid_d = 1'b1;
        end
`endif
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          a_d     = 2'd0;
          valid_d = 1'b0;
        end
      endcase

      // On a wrap the new frame's first nibble comes straight from `data`,
      // because the shadow is being reloaded on the same edge.
      if (advance) begin
        a_d          = a_next;
        cnt_d        = '0;
        frame_done_d = at_last;
        if (at_last) begin
          shadow_d = data;
          nibble_d = data[3:0];
        end else begin
          nibble_d = pick_nibble(shadow_q, a_next);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shadow_q   <= '0;
      a          <= 2'd0;
      nibble     <= 4'd0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      a          <= a_d;
      nibble     <= nibble_d;
      valid      <= valid_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
